// File: rtl/dcache_control_pkg.sv
// Shared types for the L1 data cache controller.
//   dcache_ctrl_state_t : sequencing states of the miss-handling FSM
package dcache_control_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REPLAY    = 2'd3
   } dcache_ctrl_state_t;

endpackage

// File: rtl/dcache_control_sat_counter.sv
// Saturating up-counter used for the cache performance statistics.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   inc      : add one unless already at all-ones
//   clr      : synchronous clear, takes priority over inc
//   count    : current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/dcache_control.sv
// Control FSM for a 2-way write-back L1 data cache.
// A CPU request that hits completes in the same cycle. A miss latches the
// address, writes back the dirty LRU line if needed, refills the line from
// pmem, spends one cycle letting the arrays settle, then lets the still-held
// request hit in IDLE.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   mem_read, mem_write, mem_resp: CPU handshake
//   cache_hit, dirtyout          : datapath status
//   pmem_resp, pmem_read/write   : physical memory handshake
//   write_enable .. evict_allocate: datapath selects/strobes
//   perf_clear                   : synchronous clear of the perf counters
//   hit_count, miss_count, wb_count: saturating perf counters
module dcache_control
   import dcache_control_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   input  logic                 cache_hit,
   input  logic                 dirtyout,
   input  logic                 pmem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 write_enable,
   output logic                 cache_allocate,
   output logic                 datain_mux_sel,
   output logic                 valid_in,
   output logic                 dirty_datain,
   output logic                 pmem_address_sel,
   output logic                 addr_reg_load,
   output logic                 evict_allocate,
   input  logic                 perf_clear,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   dcache_ctrl_state_t state, state_next;
   logic from_replay;   // last cycle was REPLAY: the IDLE hit is a miss completing
   logic req;
   logic hit_inc, miss_inc, wb_inc;

   assign req = mem_read | mem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         from_replay <= 1'b0;
      end else begin
         state       <= state_next;
         from_replay <= (state == REPLAY);
      end
   end

   // Outputs are forced low while rst is high so pmem strobes drop in the
   // same cycle reset arrives, even with a request still on the inputs.
   always_comb begin
      state_next       = state;
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      write_enable     = 1'b0;
      cache_allocate   = 1'b0;
      datain_mux_sel   = 1'b0;
      valid_in         = 1'b0;
      dirty_datain     = 1'b0;
      pmem_address_sel = 1'b0;
      addr_reg_load    = 1'b0;
      evict_allocate   = 1'b0;
      hit_inc          = 1'b0;
      miss_inc         = 1'b0;
      wb_inc           = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (req && cache_hit) begin
                  mem_resp = 1'b1;
                  hit_inc  = !from_replay;
                  // read+write together is handled as a write
                  if (mem_write) begin
                     write_enable   = 1'b1;
                     datain_mux_sel = 1'b1;
                     valid_in       = 1'b1;
                     dirty_datain   = 1'b1;
                  end
               end else if (req) begin
                  addr_reg_load = 1'b1;
                  miss_inc      = 1'b1;
                  state_next    = dirtyout ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_write       = 1'b1;
               pmem_address_sel = 1'b1;
               evict_allocate   = 1'b1;
               if (pmem_resp) begin
                  wb_inc     = 1'b1;
                  state_next = ALLOCATE;
               end
            end
            ALLOCATE: begin
               pmem_read      = 1'b1;
               evict_allocate = 1'b1;
               if (pmem_resp) begin
                  write_enable   = 1'b1;
                  cache_allocate = 1'b1;
                  valid_in       = 1'b1;
                  state_next     = REPLAY;
               end
            end
            REPLAY: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk(clk), .rst(rst), .inc(hit_inc), .clr(perf_clear), .count(hit_count)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk(clk), .rst(rst), .inc(miss_inc), .clr(perf_clear), .count(miss_count)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
      .clk(clk), .rst(rst), .inc(wb_inc), .clr(perf_clear), .count(wb_count)
   );

endmodule

// File: tb/tb_dcache_control.sv
// Directed bench for dcache_control (CNT_WIDTH=2 so saturation is reachable).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
// Output vector bit order:
//   [10] mem_resp [9] pmem_read [8] pmem_write [7] write_enable
//   [6] cache_allocate [5] datain_mux_sel [4] valid_in [3] dirty_datain
//   [2] pmem_address_sel [1] addr_reg_load [0] evict_allocate
module tb_dcache_control;

   logic clk = 1'b0;
   logic rst;
   logic mem_read, mem_write, cache_hit, dirtyout, pmem_resp, perf_clear;
   logic mem_resp, pmem_read, pmem_write, write_enable, cache_allocate;
   logic datain_mux_sel, valid_in, dirty_datain, pmem_address_sel;
   logic addr_reg_load, evict_allocate;
   logic [1:0] hit_count, miss_count, wb_count;
   logic [10:0] outs;

   int checks = 0;
   int failures = 0;

   localparam logic [10:0] O_NONE  = 11'b000_0000_0000;
   localparam logic [10:0] O_RHIT  = 11'b100_0000_0000;
   localparam logic [10:0] O_WHIT  = 11'b100_1011_1000;
   localparam logic [10:0] O_MISS  = 11'b000_0000_0010;
   localparam logic [10:0] O_WB    = 11'b001_0000_0101;
   localparam logic [10:0] O_ALLOC = 11'b010_0000_0001;
   localparam logic [10:0] O_FILL  = 11'b010_1101_0001;

   always #5 clk = ~clk;

   dcache_control #(.CNT_WIDTH(2)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .cache_hit(cache_hit), .dirtyout(dirtyout), .pmem_resp(pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .write_enable(write_enable), .cache_allocate(cache_allocate),
      .datain_mux_sel(datain_mux_sel), .valid_in(valid_in),
      .dirty_datain(dirty_datain), .pmem_address_sel(pmem_address_sel),
      .addr_reg_load(addr_reg_load), .evict_allocate(evict_allocate),
      .perf_clear(perf_clear),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   assign outs = {mem_resp, pmem_read, pmem_write, write_enable, cache_allocate,
                  datain_mux_sel, valid_in, dirty_datain, pmem_address_sel,
                  addr_reg_load, evict_allocate};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; mem_read = 0; mem_write = 0; cache_hit = 0; dirtyout = 0;
      pmem_resp = 0; perf_clear = 0;
      step(); step();
      #1;
      chk("reset_outs", 16'(outs), 16'(O_NONE));
      chk("reset_cnts", {10'd0, hit_count, miss_count, wb_count}, 16'd0);
      // request during reset must not produce a response
      mem_read = 1; cache_hit = 1; #1;
      chk("reset_req_masked", 16'(outs), 16'(O_NONE));
      mem_read = 0; cache_hit = 0;
      step(); rst = 1'b0;

      // read hit
      mem_read = 1; cache_hit = 1; #1;
      chk("read_hit", 16'(outs), 16'(O_RHIT));
      step(); mem_read = 0; cache_hit = 0; #1;
      chk("read_hit_cnt", 16'(hit_count), 16'd1);
      chk("idle_outs", 16'(outs), 16'(O_NONE));

      // write hit, and read+write together behaves as write
      mem_write = 1; cache_hit = 1; #1;
      chk("write_hit", 16'(outs), 16'(O_WHIT));
      step(); mem_read = 1; #1;
      chk("rw_as_write", 16'(outs), 16'(O_WHIT));
      step(); mem_read = 0; mem_write = 0; cache_hit = 0; #1;
      chk("hit_cnt_3", 16'(hit_count), 16'd3);
      perf_clear = 1; step(); perf_clear = 0; #1;
      chk("clear_cnt", 16'(hit_count), 16'd0);

      // clean read miss, pmem latency 5; mem_resp on cycle 8
      mem_read = 1; #1;
      chk("cm_c1_miss", 16'(outs), 16'(O_MISS));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("cm_alloc", 16'(outs), 16'(O_ALLOC));
      end
      step(); pmem_resp = 1; #1;
      chk("cm_c6_fill", 16'(outs), 16'(O_FILL));
      step(); pmem_resp = 0; #1;
      chk("cm_c7_replay", 16'(outs), 16'(O_NONE));
      cache_hit = 1;
      step();
      chk("cm_c8_resp", 16'(outs), 16'(O_RHIT));
      step(); mem_read = 0; cache_hit = 0; #1;
      chk("cm_miss_cnt", 16'(miss_count), 16'd1);
      chk("cm_hit_cnt", 16'(hit_count), 16'd0);

      // dirty write miss, pmem latency 2
      mem_write = 1; dirtyout = 1; #1;
      chk("dm_miss", 16'(outs), 16'(O_MISS));
      step(); dirtyout = 0; #1;
      chk("dm_wb1", 16'(outs), 16'(O_WB));
      step(); pmem_resp = 1; #1;
      chk("dm_wb2", 16'(outs), 16'(O_WB));
      step(); pmem_resp = 0; #1;
      chk("dm_alloc1", 16'(outs), 16'(O_ALLOC));
      step(); pmem_resp = 1; #1;
      chk("dm_fill", 16'(outs), 16'(O_FILL));
      step(); pmem_resp = 0; #1;
      chk("dm_replay", 16'(outs), 16'(O_NONE));
      cache_hit = 1;
      step();
      chk("dm_replay_hit", 16'(outs), 16'(O_WHIT));
      step(); mem_write = 0; cache_hit = 0; #1;
      chk("dm_cnts", {10'd0, hit_count, miss_count, wb_count}, {10'd0, 2'd0, 2'd2, 2'd1});

      // pmem_resp in IDLE is ignored; state stays IDLE
      pmem_resp = 1; #1;
      chk("idle_pmem_resp", 16'(outs), 16'(O_NONE));
      step(); pmem_resp = 0; mem_read = 1; #1;
      chk("still_idle", 16'(outs), 16'(O_MISS));

      // reset on ALLOCATE cycle 2
      step(); #1;
      chk("rst_alloc1", 16'(outs), 16'(O_ALLOC));
      step();
      chk("rst_alloc2", 16'(outs), 16'(O_ALLOC));
      rst = 1; #1;
      chk("rst_drop", 16'(outs), 16'(O_NONE));
      chk("rst_cnts", {10'd0, hit_count, miss_count, wb_count}, 16'd0);
      step(); rst = 0; #1;
      chk("rst_to_idle", 16'(outs), 16'(O_MISS));
      mem_read = 0; #1;
      step();
      chk("rst_no_fill", 16'(outs), 16'(O_NONE));

      // saturation: 5 hits on a 2-bit counter, then clear beats an increment
      mem_read = 1; cache_hit = 1;
      for (int i = 0; i < 5; i++) step();
      chk("sat_hit", 16'(hit_count), 16'd3);
      perf_clear = 1; #1;
      chk("clr_hit_resp", 16'(outs), 16'(O_RHIT));
      step(); perf_clear = 0; mem_read = 0; cache_hit = 0; #1;
      chk("clr_wins", 16'(hit_count), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
